// File: rtl/wb_arbiter.sv
// ============================================================================
// wb_arbiter
// ----------------------------------------------------------------------------
// Five-way request arbiter feeding a single registered output slot.
//
// Each cycle in which the output slot can be loaded (it is empty, or the
// downstream consumer is taking the current entry), one valid requester is
// granted through a combinational one-hot req_ready. On that clock edge its
// payload and index are captured into the output register. A consumed entry
// is replaced on the same edge, so a continuous stream moves one transfer
// per cycle.
//
// Configuration macro:
//   WB_ARB_RR_EN  defined   -> round-robin arbitration with a rotating
//                              priority pointer
//                 undefined -> fixed priority, requester 0 highest, no
//                              pointer state
//
// Parameters:
//   DATA_W     payload width per requester and of out_data
//   N_REQ      number of requesters (5; the index is a 3-bit select)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   resetn     asynchronous active-low reset
//   req_valid  [N_REQ-1:0]          per-requester valid, bit i = requester i
//   req_data   [N_REQ*DATA_W-1:0]   per-requester payload, slice i = req i
//   req_ready  [N_REQ-1:0]          per-requester accept, one-hot or zero
//   out_valid  output register holds a granted payload
//   out_data   [DATA_W-1:0]         registered payload of the winner
//   out_src    [2:0]                registered index of the winner
//   out_ready  downstream accepts out_data this cycle
// ============================================================================
module wb_arbiter #(
    parameter int DATA_W = 64,
    parameter int N_REQ  = 5
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [2:0]              out_src,
    input  logic                    out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       load;        // output slot may take a new entry this cycle
    logic       grant_any;   // at least one eligible requester found
    logic [2:0] grant_idx;   // index of the chosen requester
    logic       grant;       // a transfer happens on the next edge

`ifdef WB_ARB_RR_EN
    // Highest-priority requester index for the next arbitration.
    logic [2:0] ptr;
`endif

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    // NOTE: every signal written in an always_comb block gets a default at
    // the top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 3'd0;
`ifdef WB_ARB_RR_EN
        // Scan ptr, ptr+1, ... wrapping at N_REQ; the first valid wins.
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = 3'(idx);
            end
        end
`else
        // Scan from the lowest priority upward so the lowest valid index
        // is the last (and therefore final) assignment.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = 3'(k);
            end
        end
`endif
    end

    assign load  = (state == EMPTY) || out_ready;
    assign grant = load && grant_any;

    // req_ready is combinational and must read zero throughout reset,
    // independent of the registered state.
    always_comb begin
        req_ready = '0;
        if (resetn && grant) begin
            req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
        end
    end

    // ------------------------------------------------------------------
    // Output-slot FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (grant) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                // Holding while out_ready=0; otherwise refill or drain.
                if (out_ready) begin
                    state_next = grant ? FULL : EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    assign out_valid = (state == FULL);

    // ------------------------------------------------------------------
    // Output payload register
    // ------------------------------------------------------------------
    // NOTE: the payload register is reset to zero even though consumers
    // ignore it while EMPTY, so the post-reset output is deterministic.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_data <= '0;
            out_src  <= 3'd0;
        end else if (grant) begin
            out_data <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
            out_src  <= grant_idx;
        end
    end

`ifdef WB_ARB_RR_EN
    // ------------------------------------------------------------------
    // Round-robin pointer: the requester after the winner becomes the
    // highest priority; unchanged when nothing is granted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= 3'd0;
        end else if (grant) begin
            ptr <= (int'(grant_idx) == N_REQ - 1) ? 3'd0 : grant_idx + 3'd1;
        end
    end
`endif

endmodule
